// File: rtl/rx_prbs9_ber_checker.sv
// Receive-side PRBS9 (x^9+x^5+1) BER checker: decimates, slices, self-syncs and counts bit errors.
// Optional macro RX_BER_SAT_EN makes the bit/error counters saturate instead of wrapping.
module rx_prbs9_ber_checker #(
  parameter int NBT_IN     = 8,
  parameter int OVERSAMP   = 4,
  parameter int NB_PHASE   = 2,
  parameter int NB_CNT     = 32,
  parameter int LOCK_THR   = 32,
  parameter int UNLOCK_WIN = 128,
  parameter int UNLOCK_THR = 16
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NBT_IN-1:0]   i_sample,
  input  logic [NB_PHASE-1:0] i_phase,
  input  logic                i_clear,
  output logic                o_bit,
  output logic                o_bit_valid,
  output logic                o_locked,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  localparam int RUN_W = $clog2(LOCK_THR + 1);
  localparam int WB_W  = $clog2(UNLOCK_WIN + 1);
  localparam int WE_W  = $clog2(UNLOCK_THR + 1);

  localparam logic [NB_PHASE-1:0] PH_LAST  = NB_PHASE'(OVERSAMP - 1);
  localparam logic [RUN_W-1:0]    RUN_LAST = RUN_W'(LOCK_THR - 1);
  localparam logic [WB_W-1:0]     WIN_LAST = WB_W'(UNLOCK_WIN - 1);
  localparam logic [WE_W-1:0]     ERR_LAST = WE_W'(UNLOCK_THR - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CHECK,
    ST_LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [NB_PHASE-1:0] ph_cnt_q, ph_cnt_d;
  logic                bit_q, bit_d;
  logic                bit_valid_q, bit_valid_d;
  logic [8:0]          lfsr_q, lfsr_d;
  logic [3:0]          load_cnt_q, load_cnt_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [WB_W-1:0]     win_bits_q, win_bits_d;
  logic [WE_W-1:0]     win_errs_q, win_errs_d;
  logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;

  logic keep;
  logic pred;
  logic mismatch;

  // Only the sign bit feeds the slicer.
  logic unused_sample;
  assign unused_sample = ^i_sample[NBT_IN-2:0];

  function automatic logic [NB_CNT-1:0] cnt_inc(input logic [NB_CNT-1:0] v);
`ifdef RX_BER_SAT_EN
    return (&v) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    ph_cnt_d    = ph_cnt_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    lfsr_d      = lfsr_q;
    load_cnt_d  = load_cnt_q;
    run_d       = run_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;

    keep     = i_enable && (ph_cnt_q == i_phase);
    pred     = lfsr_q[8] ^ lfsr_q[4];
    mismatch = bit_q ^ pred;

    if (i_enable) begin
      ph_cnt_d = (ph_cnt_q == PH_LAST) ? '0 : ph_cnt_q + 1'b1;
    end
    if (keep) begin
      bit_valid_d = 1'b1;
      bit_d       = i_sample[NBT_IN-1];
    end

    // The registered bit is consumed in the cycle it is presented on o_bit.
    if (bit_valid_q) begin
      case (state_q)
        ST_LOAD: begin
          lfsr_d = {lfsr_q[7:0], bit_q};
          if (load_cnt_q == 4'd8) begin
            state_d    = ST_CHECK;
            load_cnt_d = '0;
            run_d      = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          lfsr_d = {lfsr_q[7:0], bit_q};
          if (!mismatch) begin
            if (run_q == RUN_LAST) begin
              state_d    = ST_LOCKED;
              run_d      = '0;
              win_bits_d = '0;
              win_errs_d = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          // Feeding back the prediction keeps a single bad bit from corrupting later predictions.
          lfsr_d     = {lfsr_q[7:0], pred};
          bit_cnt_d  = cnt_inc(bit_cnt_q);
          win_bits_d = win_bits_q + 1'b1;
          if (mismatch) begin
            err_cnt_d  = cnt_inc(err_cnt_q);
            win_errs_d = win_errs_q + 1'b1;
          end
          if (mismatch && (win_errs_q == ERR_LAST)) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
          end else if (win_bits_q == WIN_LAST) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end
        end
        default: begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
        end
      endcase
    end

    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= ST_LOAD;
      ph_cnt_q    <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      lfsr_q      <= 9'h000;
      load_cnt_q  <= '0;
      run_q       <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ph_cnt_q    <= ph_cnt_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      lfsr_q      <= lfsr_d;
      load_cnt_q  <= load_cnt_d;
      run_q       <= run_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_locked    = (state_q == ST_LOCKED);
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_rx_prbs9_ber_checker.sv
// Bench for rx_prbs9_ber_checker: a sequence-level reference model checked every cycle plus directed literal checks.
// A second instance with NB_CNT=4 exercises counter wrap, or saturation when RX_BER_SAT_EN is defined.
module tb_rx_prbs9_ber_checker;

  localparam int LOCK_THR   = 32;
  localparam int UNLOCK_WIN = 128;
  localparam int UNLOCK_THR = 16;
`ifdef RX_BER_SAT_EN
  localparam int SMALL_EXP = 15;
`else
  localparam int SMALL_EXP = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] smp = 8'h00;
  logic [1:0] phase = 2'd0;

  logic        o_bit, o_bit_valid, o_locked;
  logic [31:0] o_bit_count, o_err_count;
  logic        s_bit, s_bit_valid, s_locked;
  logic [3:0]  s_bit_count, s_err_count;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  rx_prbs9_ber_checker dut (
    .clk(clk), .i_reset(rst), .i_enable(en), .i_sample(smp), .i_phase(phase), .i_clear(clr),
    .o_bit(o_bit), .o_bit_valid(o_bit_valid), .o_locked(o_locked),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  rx_prbs9_ber_checker #(.NB_CNT(4)) dut_small (
    .clk(clk), .i_reset(rst), .i_enable(en), .i_sample(smp), .i_phase(phase), .i_clear(clr),
    .o_bit(s_bit), .o_bit_valid(s_bit_valid), .o_locked(s_locked),
    .o_bit_count(s_bit_count), .o_err_count(s_err_count)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: tracks the received sequence against the PRBS9 recurrence b[n] = b[n-9] ^ b[n-5].
  typedef enum {MD_ACQ, MD_VERIFY, MD_TRACK} md_t;
  md_t         m_mode;
  bit          m_ready = 1'b0;
  int          m_ph, m_loaded, m_run, m_wb, m_we;
  bit          m_valid, m_bit;
  bit          hist[$];
  int unsigned m_bits, m_errs;
  int          sm_bits, sm_errs;

  function automatic int small_inc(input int v);
`ifdef RX_BER_SAT_EN
    return (v < 15) ? v + 1 : 15;
`else
    return (v + 1) % 16;
`endif
  endfunction

  task automatic modelBit(input bit b);
    bit p;
    p = hist[0] ^ hist[4];
    case (m_mode)
      MD_ACQ: begin
        hist.push_back(b);
        void'(hist.pop_front());
        m_loaded++;
        if (m_loaded == 9) begin
          m_mode = MD_VERIFY;
          m_run  = 0;
        end
      end
      MD_VERIFY: begin
        hist.push_back(b);
        void'(hist.pop_front());
        if (b == p) begin
          m_run++;
          if (m_run == LOCK_THR) begin
            m_mode = MD_TRACK;
            m_wb   = 0;
            m_we   = 0;
          end
        end else begin
          m_mode   = MD_ACQ;
          m_loaded = 0;
        end
      end
      default: begin
        hist.push_back(p);
        void'(hist.pop_front());
        m_bits++;
        sm_bits = small_inc(sm_bits);
        m_wb++;
        if (b != p) begin
          m_errs++;
          sm_errs = small_inc(sm_errs);
          m_we++;
        end
        if (m_we == UNLOCK_THR) begin
          m_mode   = MD_ACQ;
          m_loaded = 0;
        end else if (m_wb == UNLOCK_WIN) begin
          m_wb = 0;
          m_we = 0;
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ready  = 1'b1;
      m_mode   = MD_ACQ;
      m_ph     = 0;
      m_valid  = 1'b0;
      m_bit    = 1'b0;
      m_loaded = 0;
      m_run    = 0;
      m_wb     = 0;
      m_we     = 0;
      m_bits   = 0;
      m_errs   = 0;
      sm_bits  = 0;
      sm_errs  = 0;
      hist.delete();
      for (int i = 0; i < 9; i++) hist.push_back(1'b0);
    end else begin
      if (m_valid) modelBit(m_bit);
      if (clr) begin
        m_bits  = 0;
        m_errs  = 0;
        sm_bits = 0;
        sm_errs = 0;
      end
      m_valid = 1'b0;
      if (en) begin
        if (m_ph == int'(phase)) begin
          m_valid = 1'b1;
          m_bit   = smp[7];
        end
        m_ph = (m_ph + 1) % 4;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      checkOutput("bit_valid", longint'(o_bit_valid), longint'(m_valid));
      checkOutput("bit", longint'(o_bit), longint'(m_bit));
      checkOutput("locked", longint'(o_locked), longint'(m_mode == MD_TRACK));
      checkOutput("bit_count", longint'(o_bit_count), longint'(m_bits));
      checkOutput("err_count", longint'(o_err_count), longint'(m_errs));
      checkOutput("small_locked", longint'(s_locked), longint'(m_mode == MD_TRACK));
      checkOutput("small_bit_count", longint'(s_bit_count), longint'(sm_bits));
      checkOutput("small_err_count", longint'(s_err_count), longint'(sm_errs));
      if (o_bit_valid) strobe_cnt++;
    end
  end

  // Transmit-side PRBS9 generator, seed 9'h1AA.
  logic [8:0] gen = 9'h1AA;
  function automatic bit nextPrbs();
    bit o;
    o   = gen[8] ^ gen[4];
    gen = {gen[7:0], o};
    return o;
  endfunction

  task automatic applyStimulus(input logic e, input logic [7:0] s, input logic c);
    @(posedge clk);
    #2;
    en  = e;
    smp = s;
    clr = c;
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Flat symbol: bit1 -> negative, bit0 -> positive on all four samples.
  task automatic sendSymbol(input bit inv, input int clr_at);
    bit b;
    b = nextPrbs() ^ inv;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, b ? 8'hC0 : 8'h40, k == clr_at);
  endtask

  // Shaped symbol: correct-sign peak at phase 2, wrong-sign small values elsewhere.
  task automatic sendShaped();
    bit b;
    b = nextPrbs();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) applyStimulus(1'b1, b ? 8'hC0 : 8'h40, 1'b0);
      else        applyStimulus(1'b1, b ? 8'h10 : 8'hF0, 1'b0);
    end
  endtask

  initial begin
    doReset();
    checkOutput("reset_locked", longint'(o_locked), 0);
    checkOutput("reset_bits", longint'(o_bit_count), 0);
    checkOutput("reset_errs", longint'(o_err_count), 0);
    checkOutput("reset_valid", longint'(o_bit_valid), 0);

    repeat (40) sendSymbol(1'b0, -1);
    checkOutput("lock_after_40", longint'(o_locked), 0);
    sendSymbol(1'b0, -1);
    checkOutput("lock_after_41", longint'(o_locked), 1);
    checkOutput("bits_at_lock", longint'(o_bit_count), 0);

    repeat (10000) sendSymbol(1'b0, -1);
    checkOutput("bits_10000", longint'(o_bit_count), 10000);
    checkOutput("errs_10000", longint'(o_err_count), 0);

    repeat (12) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("hold_bits", longint'(o_bit_count), 10000);

    sendSymbol(1'b0, 0);
    repeat (498) sendSymbol(1'b0, -1);
    checkOutput("bits_499", longint'(o_bit_count), 499);
    sendSymbol(1'b1, -1);
    checkOutput("single_err", longint'(o_err_count), 1);
    checkOutput("single_err_locked", longint'(o_locked), 1);
    repeat (50) sendSymbol(1'b0, -1);
    checkOutput("no_propagation", longint'(o_err_count), 1);
    checkOutput("bits_550", longint'(o_bit_count), 550);

    sendSymbol(1'b1, 1);
    checkOutput("clear_bits", longint'(o_bit_count), 0);
    checkOutput("clear_errs", longint'(o_err_count), 0);
    checkOutput("clear_locked", longint'(o_locked), 1);

    doReset();
    checkOutput("midreset_locked", longint'(o_locked), 0);
    checkOutput("midreset_bits", longint'(o_bit_count), 0);
    repeat (41) sendSymbol(1'b0, -1);
    checkOutput("relock_after_reset", longint'(o_locked), 1);
    for (int k = 0; k <= 161; k++) begin
      sendSymbol((k % 8 == 0) && (k <= 120), -1);
      if (k == 119) begin
        checkOutput("errs_15", longint'(o_err_count), 15);
        checkOutput("locked_at_15", longint'(o_locked), 1);
      end
      if (k == 120) begin
        checkOutput("errs_16", longint'(o_err_count), 16);
        checkOutput("unlocked_at_16", longint'(o_locked), 0);
        checkOutput("bits_121", longint'(o_bit_count), 121);
      end
      if (k == 160) checkOutput("relock_40", longint'(o_locked), 0);
      if (k == 161) checkOutput("relock_41", longint'(o_locked), 1);
    end

    sendSymbol(1'b0, 0);
    repeat (19) sendSymbol(1'b0, -1);
    checkOutput("bits_20", longint'(o_bit_count), 20);
    checkOutput("small_bits_20", longint'(s_bit_count), SMALL_EXP);

    for (int p = 0; p < 4; p++) begin
      doReset();
      phase = 2'(p);
      strobe_cnt = 0;
      repeat (80) sendShaped();
      repeat (2) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("phase_strobes", longint'(strobe_cnt), 80);
      checkOutput("phase_locked", longint'(o_locked), (p == 2) ? 1 : 0);
      if (p == 2) checkOutput("phase2_errs", longint'(o_err_count), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
